// File: rtl/Purple_Jade_pkg.sv
// Shared constants and types for the execute-side load pipeline.
package Purple_Jade_pkg;

  localparam int unsigned WORD_SIZE_P  = 16;
  localparam int unsigned NUM_PHYS_REG = 64;
  localparam int unsigned ROB_ENTRY    = 32;
  localparam int unsigned SB_ENTRY     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StWb
  } ld_state_e;

  typedef struct packed {
    logic [$clog2(NUM_PHYS_REG)-1:0] addr;
    logic [WORD_SIZE_P-1:0]          data;
    logic [$clog2(ROB_ENTRY)-1:0]    rob_num;
  } ld_wb_s;

endpackage

// File: rtl/load_unit.sv
// Single-entry load pipeline: address generation, store-buffer forwarding and memory read,
// with a registered writeback port and flush on misprediction.
module load_unit #(
  parameter int unsigned WORD_SIZE_P  = Purple_Jade_pkg::WORD_SIZE_P,
  parameter int unsigned NUM_PHYS_REG = Purple_Jade_pkg::NUM_PHYS_REG,
  parameter int unsigned ROB_ENTRY    = Purple_Jade_pkg::ROB_ENTRY,
  parameter int unsigned SB_ENTRY     = Purple_Jade_pkg::SB_ENTRY
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            issue_ld_v_i,
  output logic                            issue_ld_ready_o,
  input  logic [WORD_SIZE_P-1:0]          issue_base_i,
  input  logic [WORD_SIZE_P-1:0]          issue_offset_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0] issue_dest_i,
  input  logic [$clog2(ROB_ENTRY)-1:0]    issue_rob_num_i,
  input  logic [$clog2(SB_ENTRY)-1:0]     issue_sb_num_i,
  output logic [WORD_SIZE_P-1:0]          exe_mem_addr_o,
  output logic [WORD_SIZE_P-1:0]          exe_ld_bypass_addr_o,
  output logic [$clog2(SB_ENTRY)-1:0]     exe_ld_pass_sb_num_o,
  input  logic                            sb_ld_pass_valid_i,
  input  logic [WORD_SIZE_P-1:0]          sb_ld_pass_value_i,
  input  logic [WORD_SIZE_P-1:0]          exe_mem_data_i,
  input  logic                            rob_mispredict_i,
  output logic                            wb_v_o,
  input  logic                            wb_ready_i,
  output logic [$clog2(NUM_PHYS_REG)-1:0] wb_addr_o,
  output logic [WORD_SIZE_P-1:0]          wb_data_o,
  output logic [$clog2(ROB_ENTRY)-1:0]    wb_rob_num_o
);

  import Purple_Jade_pkg::*;

  ld_state_e                       state_q;
  logic [WORD_SIZE_P-1:0]          addr_q;
  logic [$clog2(SB_ENTRY)-1:0]     sb_num_q;
  logic [$clog2(NUM_PHYS_REG)-1:0] dest_q;
  logic [$clog2(ROB_ENTRY)-1:0]    rob_num_q;
  logic [WORD_SIZE_P-1:0]          data_q;
  logic                            pass_v_q;
  logic [WORD_SIZE_P-1:0]          pass_val_q;

  logic   in_wb;
  logic   accept;
  ld_wb_s wb_bundle;

  assign in_wb = (state_q == StWb);

  // A new load may enter in the handoff cycle, giving one load per three cycles.
  assign issue_ld_ready_o = ~reset_i & ~rob_mispredict_i &
                            ((state_q == StIdle) | (in_wb & wb_ready_i));
  assign accept           = issue_ld_v_i & issue_ld_ready_o;

  // Gated by flush and reset so a discarded result is never handed off.
  assign wb_v_o = in_wb & ~rob_mispredict_i & ~reset_i;

  assign exe_mem_addr_o       = addr_q;
  assign exe_ld_bypass_addr_o = addr_q;
  assign exe_ld_pass_sb_num_o = sb_num_q;

  assign wb_bundle    = '{addr: dest_q, data: data_q, rob_num: rob_num_q};
  assign wb_addr_o    = wb_bundle.addr;
  assign wb_data_o    = wb_bundle.data;
  assign wb_rob_num_o = wb_bundle.rob_num;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      sb_num_q   <= '0;
      dest_q     <= '0;
      rob_num_q  <= '0;
      data_q     <= '0;
      pass_v_q   <= 1'b0;
      pass_val_q <= '0;
    end else begin
      if (accept) begin
        addr_q    <= issue_base_i + issue_offset_i;
        sb_num_q  <= issue_sb_num_i;
        dest_q    <= issue_dest_i;
        rob_num_q <= issue_rob_num_i;
      end

      case (state_q)
        StIdle: state_q <= accept ? StReq : StIdle;
        StReq: begin
          pass_v_q   <= sb_ld_pass_valid_i;
          pass_val_q <= sb_ld_pass_value_i;
          state_q    <= StResp;
        end
        StResp: begin
          data_q  <= pass_v_q ? pass_val_q : exe_mem_data_i;
          state_q <= StWb;
        end
        StWb: begin
          if (wb_ready_i) state_q <= accept ? StReq : StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (rob_mispredict_i) state_q <= StIdle;
    end
  end

endmodule
